// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
package pipe_stage_elastic_pkg;

    localparam int unsigned STAGE_DEPTH_DEFAULT = 2;

    // Valid/ready pair for one side of a stage.
    typedef struct packed {
        logic valid;
        logic ready;
    } stage_hs_t;

    // Pointer width for an N-entry ring; never narrower than one bit.
    function automatic int unsigned ptr_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_wrap_ptr.sv
// Ring-buffer pointer that counts 0..N-1 and wraps, with synchronous clear.
module wrap_ptr #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_q, ptr_d;

    // Next pointer: clear wins, otherwise advance with explicit wrap (works for non-pow2 N).
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready on both sides, DEPTH-entry ring buffer,
// plus stage-level stall (freeze) and bubble (flush).
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = STAGE_DEPTH_DEFAULT,
    parameter int unsigned PTR_W = ptr_width(DEPTH),
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             bubble,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count
);

    stage_hs_t        in_hs, out_hs;
    logic             push, pop;
    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Handshake decode; ready looks only at registered count and stall, never out_ready.
    always_comb begin
        in_hs.valid  = in_valid;
        in_hs.ready  = !stall && (count_q != CNT_W'(DEPTH));
        out_hs.valid = (count_q != '0);
        out_hs.ready = out_ready;
        push         = in_hs.valid && in_hs.ready && !bubble;
        pop          = out_hs.valid && out_hs.ready && !stall && !bubble;
    end

    // Occupancy next state: bubble flushes, stall freezes, otherwise +push -pop.
    always_comb begin
        count_d = count_q;
        if (bubble) begin
            count_d = '0;
        end else if (!stall) begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Payload storage; left unreset since out_data is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail] <= in_data;
        end
    end

    wrap_ptr #(
        .N (DEPTH),
        .W (PTR_W)
    ) u_head (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .clr (bubble),
        .ptr (head)
    );

    wrap_ptr #(
        .N (DEPTH),
        .W (PTR_W)
    ) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .clr (bubble),
        .ptr (tail)
    );

    // Output drive; zero payload when empty matches the fixed stage bubble convention.
    always_comb begin
        in_ready  = in_hs.ready;
        out_valid = out_hs.valid;
        out_data  = out_hs.valid ? mem_q[head] : '0;
        count     = count_q;
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic: a DEPTH=2 instance for the handshake,
// stall, bubble and reset cases, and a DEPTH=3 instance for ring-wrap streaming.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // DEPTH=2 instance.
    logic        a_stall = 0, a_bubble = 0, a_in_valid = 0, a_out_ready = 0;
    logic [31:0] a_in_data = '0;
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_count;

    // DEPTH=3 instance.
    logic        b_stall = 0, b_bubble = 0, b_in_valid = 0, b_out_ready = 0;
    logic [31:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_count;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .stall     (a_stall),
        .bubble    (a_bubble),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .count     (a_count)
    );

    pipe_stage_elastic #(.WIDTH(32), .DEPTH(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .stall     (b_stall),
        .bubble    (b_bubble),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Invariants sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("a_cnt_le_depth", 32'(a_count <= 2'd2), 32'd1);
            check_eq("b_cnt_le_depth", 32'(b_count <= 2'd3), 32'd1);
            if (a_count == 2'd0) check_eq("a_empty_zero", a_out_data, 32'd0);
            if (b_count == 2'd0) check_eq("b_empty_zero", b_out_data, 32'd0);
            if (a_count == 2'd2) check_eq("a_full_no_ready", 32'(a_in_ready), 32'd0);
            if (b_count == 2'd3) check_eq("b_full_no_ready", 32'(b_in_ready), 32'd0);
        end
    end

    initial begin
        logic [31:0] exp_next;
        int          sent;
        int          cyc;
        logic        do_push, do_pop;

        // Reset state.
        #2;
        check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
        check_eq("rst_out_data", a_out_data, 32'd0);
        check_eq("rst_in_ready", 32'(a_in_ready), 32'd1);
        check_eq("rst_count", 32'(a_count), 32'd0);
        #10 rst = 1'b1;
        step();

        // 1: streaming at full rate, one-cycle latency.
        a_out_ready = 1;
        a_in_valid  = 1;
        a_in_data   = 32'hA;
        step();
        check_eq("t1_data_a", a_out_data, 32'hA);
        check_eq("t1_cnt_a", 32'(a_count), 32'd1);
        a_in_data = 32'hB;
        step();
        check_eq("t1_data_b", a_out_data, 32'hB);
        check_eq("t1_cnt_b", 32'(a_count), 32'd1);
        a_in_data = 32'hC;
        step();
        check_eq("t1_data_c", a_out_data, 32'hC);
        check_eq("t1_cnt_c", 32'(a_count), 32'd1);
        a_in_valid = 0;
        step();
        check_eq("t1_drained", 32'(a_out_valid), 32'd0);

        // 2: backpressure fills the buffer, then drains in order.
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'h11;
        step();
        a_in_data = 32'h22;
        step();
        a_in_data = 32'h33;
        check_eq("t2_full_ready", 32'(a_in_ready), 32'd0);
        check_eq("t2_full_cnt", 32'(a_count), 32'd2);
        step();
        check_eq("t2_held_cnt", 32'(a_count), 32'd2);
        check_eq("t2_head", a_out_data, 32'h11);
        a_out_ready = 1;
        check_eq("t2_no_bypass", 32'(a_in_ready), 32'd0);
        step();
        check_eq("t2_out_22", a_out_data, 32'h22);
        check_eq("t2_cnt_1", 32'(a_count), 32'd1);
        step();
        check_eq("t2_out_33", a_out_data, 32'h33);
        check_eq("t2_cnt_1b", 32'(a_count), 32'd1);
        a_in_valid = 0;
        step();
        check_eq("t2_empty", 32'(a_count), 32'd0);

        // 3: stall freezes a full stage.
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'h5;
        step();
        a_in_data = 32'h6;
        step();
        a_stall     = 1;
        a_in_data   = 32'h7;
        a_out_ready = 1;
        check_eq("t3_ready_low", 32'(a_in_ready), 32'd0);
        check_eq("t3_valid_high", 32'(a_out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t3_cnt", 32'(a_count), 32'd2);
            check_eq("t3_data", a_out_data, 32'h5);
        end

        // 4: bubble overrides stall and discards the same-cycle push.
        a_bubble = 1;
        step();
        check_eq("t4_cnt", 32'(a_count), 32'd0);
        check_eq("t4_valid", 32'(a_out_valid), 32'd0);
        check_eq("t4_data", a_out_data, 32'd0);
        a_bubble   = 0;
        a_stall    = 0;
        a_in_valid = 0;
        step();
        check_eq("t4_not_stored", 32'(a_count), 32'd0);

        // 5: DEPTH=3 streaming 1..20 under random backpressure.
        exp_next = 32'd1;
        sent     = 0;
        cyc      = 0;
        while ((exp_next <= 32'd20) && (cyc < 500)) begin
            b_in_valid  = (sent < 20);
            b_in_data   = 32'(sent + 1);
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            do_push = b_in_valid && b_in_ready;
            do_pop  = b_out_valid && b_out_ready;
            if (do_pop) begin
                check_eq("t5_order", b_out_data, exp_next);
                exp_next++;
            end
            step();
            if (do_push) sent++;
            cyc++;
        end
        b_in_valid  = 0;
        b_out_ready = 0;
        check_eq("t5_all_out", exp_next, 32'd21);
        check_eq("t5_final_cnt", 32'(b_count), 32'd0);

        // 6: asynchronous reset mid-stream.
        a_out_ready = 0;
        a_in_valid  = 1;
        a_in_data   = 32'h99;
        step();
        a_in_valid = 0;
        check_eq("t6_pre_cnt", 32'(a_count), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("t6_async_valid", 32'(a_out_valid), 32'd0);
        check_eq("t6_async_data", a_out_data, 32'd0);
        check_eq("t6_async_cnt", 32'(a_count), 32'd0);
        #2 rst = 1'b1;
        step();
        a_out_ready = 1;
        a_in_valid  = 1;
        a_in_data   = 32'h42;
        step();
        check_eq("t6_post_data", a_out_data, 32'h42);
        check_eq("t6_post_cnt", 32'(a_count), 32'd1);
        a_in_valid = 0;
        step();
        check_eq("t6_post_empty", 32'(a_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
